// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the digit-serial add/subtract unit:
//   state_t                 FSM encoding (ST_IDLE, ST_RUN, ST_DONE)
//   clog2()                 width helper for the digit counter
//   `ADDSUB_CHECK_PARAMS    elaboration-time legality check for N and K
// -----------------------------------------------------------------------------
`ifndef ADDSUB_PKG_SV
`define ADDSUB_PKG_SV

// Stops elaboration when the width/digit combination cannot be processed
// by a whole number of equal slices.
`define ADDSUB_CHECK_PARAMS(n_, k_) \
  if ((n_) < 2 || (k_) < 1 || (k_) > (n_) || ((n_) % (k_)) != 0) begin : g_bad_params \
    $error("addsub: illegal parameters N=%0d K=%0d", (n_), (k_)); \
  end

package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Smallest width w with 2**w >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

`endif

// File: rtl/addsub_serial_if.sv
// -----------------------------------------------------------------------------
// addsub_serial_if
// Operation handshake and result bus of the serial add/subtract unit.
//   start, sub, a, b              : request side (driven by the master)
//   busy, done, result, bout,
//   ovf, zero                     : status/result side (driven by the unit)
// Modports: master (requester), slave (addsub_serial).
// -----------------------------------------------------------------------------
interface addsub_serial_if #(
  parameter int N = 8
);
  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         bout;
  logic         ovf;
  logic         zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, bout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, bout, ovf, zero
  );
endinterface

// File: rtl/addsub_digit.sv
// -----------------------------------------------------------------------------
// addsub_digit
// Combinational K-bit ripple adder slice, reused once per RUN cycle.
//   a, b   : K-bit digit operands
//   cin    : carry into bit 0
//   sum    : K-bit digit sum
//   cout   : carry out of bit K-1
//   c_msb  : carry into bit K-1 (with cout gives signed overflow)
// -----------------------------------------------------------------------------
module addsub_digit #(
  parameter int K = 2
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [K:0] carry;

  // Ripple the carry through the slice; carry[i] is the carry into bit i.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < K; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = carry[K];
  assign c_msb = carry[K-1];

endmodule

// File: rtl/addsub_serial.sv
// -----------------------------------------------------------------------------
// addsub_serial
// Digit-serial add/subtract: an N-bit a+b or a-b is computed K bits per
// clock over N/K RUN cycles through one shared addsub_digit slice.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : addsub_serial_if.slave
//            start/sub/a/b sampled in IDLE or DONE; busy high in RUN;
//            done pulses one cycle with result, bout, ovf, zero valid.
// -----------------------------------------------------------------------------
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  addsub_serial_if.slave  bus
);

  `ADDSUB_CHECK_PARAMS(N, K)

  localparam int DIGITS = N / K;
  localparam int CW     = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  res_sh;
  logic [N-1:0]  res_next;
  logic [N-1:0]  sum_ext;
  logic          carry;
  logic          op;
  logic          bout_q;
  logic          ovf_q;
  logic          zero_q;
  logic [CW-1:0] cnt;
  logic [K-1:0]  slice_sum;
  logic          slice_cout;
  logic          slice_cmsb;
  logic          accept;
  logic          last;

  // A new request is only taken when no operation is in flight.
  assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
  assign last   = (cnt == LAST_DIGIT);

  addsub_digit #(.K(K)) u_digit (
    .a     (a_sh[K-1:0]),
    .b     (b_sh[K-1:0]),
    .cin   (carry),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  // Each new sum digit enters at the MSB end while older digits move down,
  // so after N/K digits the LSB digit has reached bit 0.
  always_comb begin
    sum_ext          = '0;
    sum_ext[K-1:0]   = slice_sum;
    res_next         = (res_sh >> K) | (sum_ext << (N - K));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: RUN ignores start, DONE can chain straight into RUN.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_next = last ? ST_DONE : ST_RUN;
      ST_DONE: state_next = bus.start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: subtraction is a + ~b + 1, so b is inverted and the carry
  // preset on accept. Flags are captured from the final digit only, so
  // they keep their values until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      op     <= 1'b0;
      cnt    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub;
      op    <= bus.sub;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> K;
      b_sh   <= b_sh >> K;
      res_sh <= res_next;
      carry  <= slice_cout;
      cnt    <= cnt + CW'(1);
      if (last) begin
        bout_q <= op ? ~slice_cout : slice_cout;
        ovf_q  <= slice_cmsb ^ slice_cout;
        zero_q <= (res_next == '0);
      end
    end
  end

  // Outputs come straight from flops or the state register.
  always_comb begin
    bus.busy   = (state == ST_RUN);
    bus.done   = (state == ST_DONE);
    bus.result = res_sh;
    bus.bout   = bout_q;
    bus.ovf    = ovf_q;
    bus.zero   = zero_q;
  end

endmodule

// File: tb/tb_addsub_serial.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial
// Scoreboard bench for addsub_serial: N=8/K=2 directed vectors with
// hand-computed results, plus exhaustive N=4 runs with K=1 and K=4
// checked against an arithmetic reference model. Expected responses are
// queued at acceptance and popped by a monitor whenever done is seen.
// Packed expectation: {zero, ovf, bout, result[7:0]}.
// -----------------------------------------------------------------------------
module tb_addsub_serial;

  typedef struct {
    logic [10:0] exp;
    int          id;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   op_id  = 0;
  exp_t q8[$];
  exp_t q4a[$];
  exp_t q4b[$];

  addsub_serial_if #(.N(8)) bus8 ();
  addsub_serial_if #(.N(4)) bus4a ();
  addsub_serial_if #(.N(4)) bus4b ();

  addsub_serial #(.N(8), .K(2)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  addsub_serial #(.N(4), .K(1)) dut4a (.clk(clk), .rst_n(rst_n), .bus(bus4a));
  addsub_serial #(.N(4), .K(4)) dut4b (.clk(clk), .rst_n(rst_n), .bus(bus4b));

  always #5 clk = ~clk;

  // Integer reference: result mod 2^n, unsigned carry/borrow, and signed
  // overflow from the true two's-complement value leaving the range.
  function automatic logic [10:0] model(input int n, input int a, input int b, input int s);
    int   m, r, sa, sb, t;
    logic bo, ov, z;
    m = 1 << n;
    if (s != 0) begin
      r  = (a - b + m) % m;
      bo = (a < b);
    end else begin
      r  = (a + b) % m;
      bo = ((a + b) >= m);
    end
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    t  = (s != 0) ? sa - sb : sa + sb;
    ov = (t < -(m / 2)) || (t >= m / 2);
    z  = (r == 0);
    return {z, ov, bo, 8'(r)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Drives one request from a negedge, records the expectation at the
  // accepting edge, and returns at the following negedge with start low.
  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic s,
                                input logic [10:0] exp, input bit expect_done);
    exp_t e;
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.sub   = s;
    @(posedge clk);
    op_id++;
    e.exp = exp;
    e.id  = op_id;
    if (expect_done) q8.push_back(e);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic applyStimulus4(input int sel, input int a, input int b, input int s);
    exp_t e;
    if (sel == 0) begin
      bus4a.start = 1'b1; bus4a.a = 4'(a); bus4a.b = 4'(b); bus4a.sub = s[0];
    end else begin
      bus4b.start = 1'b1; bus4b.a = 4'(a); bus4b.b = 4'(b); bus4b.sub = s[0];
    end
    @(posedge clk);
    op_id++;
    e.exp = model(4, a, b, s);
    e.id  = op_id;
    if (sel == 0) q4a.push_back(e);
    else          q4b.push_back(e);
    @(negedge clk);
    bus4a.start = 1'b0;
    bus4b.start = 1'b0;
  endtask

  task automatic waitDone8();
    int n = 0;
    while (!bus8.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.done) checkOutput("dut8 done timeout", 32'(bus8.done), 32'(1));
  endtask

  task automatic waitDone4(input int sel);
    int   n = 0;
    logic d;
    d = (sel == 0) ? bus4a.done : bus4b.done;
    while (!d && n < 20) begin
      @(negedge clk);
      n++;
      d = (sel == 0) ? bus4a.done : bus4b.done;
    end
    if (!d) checkOutput($sformatf("dut4 sel%0d done timeout", sel), 32'(d), 32'(1));
  endtask

  task automatic runOp8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [10:0] exp);
    applyStimulus8(a, b, s, exp, 1'b1);
    waitDone8();
    @(negedge clk);
  endtask

  // Pops one expectation per done pulse on each unit; a done with nothing
  // pending is itself a failure.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus8.done) begin
        checkOutput("dut8 done with op pending", 32'(q8.size() != 0), 32'(1));
        if (q8.size() != 0) begin
          e = q8.pop_front();
          checkOutput($sformatf("dut8 op%0d", e.id),
                      32'({bus8.zero, bus8.ovf, bus8.bout, bus8.result}), 32'(e.exp));
        end
      end
      if (bus4a.done) begin
        checkOutput("dut4 K1 done with op pending", 32'(q4a.size() != 0), 32'(1));
        if (q4a.size() != 0) begin
          e = q4a.pop_front();
          checkOutput($sformatf("dut4 K1 op%0d", e.id),
                      32'({bus4a.zero, bus4a.ovf, bus4a.bout, 4'h0, bus4a.result}), 32'(e.exp));
        end
      end
      if (bus4b.done) begin
        checkOutput("dut4 K4 done with op pending", 32'(q4b.size() != 0), 32'(1));
        if (q4b.size() != 0) begin
          e = q4b.pop_front();
          checkOutput($sformatf("dut4 K4 op%0d", e.id),
                      32'({bus4b.zero, bus4b.ovf, bus4b.bout, 4'h0, bus4b.result}), 32'(e.exp));
        end
      end
    end
  endtask

  task automatic runAll();
    // Reset state.
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset outputs",
                32'({bus8.busy, bus8.done, bus8.zero, bus8.ovf, bus8.bout, bus8.result}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 100+27 with latency/busy profile.
    applyStimulus8(8'd100, 8'd27, 1'b0, 11'h07F, 1'b1);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("busy,done after E%0d", c), 32'({bus8.busy, bus8.done}), 32'(2'b10));
      @(negedge clk);
    end
    checkOutput("busy,done after E4", 32'({bus8.busy, bus8.done}), 32'(2'b01));
    @(negedge clk);
    checkOutput("done single cycle", 32'(bus8.done), 32'(0));

    // Directed arithmetic vectors: {zero, ovf, bout, result}.
    runOp8(8'd5,   8'd2,   1'b1, 11'h003);
    runOp8(8'd2,   8'd5,   1'b1, 11'h1FD);
    runOp8(8'd127, 8'd1,   1'b0, 11'h280);
    runOp8(8'hFF,  8'h01,  1'b0, 11'h500);
    runOp8(8'd3,   8'd3,   1'b1, 11'h400);
    runOp8(8'h80,  8'h01,  1'b1, 11'h27F);
    runOp8(8'h5A,  8'h00,  1'b1, 11'h05A);
    runOp8(8'h00,  8'h80,  1'b1, 11'h380);
    runOp8(8'hC0,  8'hC0,  1'b0, 11'h180);

    // start pulsed in RUN with other operands must be ignored.
    applyStimulus8(8'h12, 8'h34, 1'b0, 11'h046, 1'b1);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.sub = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    waitDone8();
    for (int c = 0; c < 3; c++) @(negedge clk);
    checkOutput("idle after ignored start", 32'(bus8.busy), 32'(0));

    // Back-to-back: start held while done is high.
    applyStimulus8(8'h10, 8'h20, 1'b0, 11'h030, 1'b1);
    waitDone8();
    applyStimulus8(8'h50, 8'h60, 1'b1, 11'h1F0, 1'b1);
    checkOutput("back-to-back accepted", 32'(bus8.busy), 32'(1));
    waitDone8();
    @(negedge clk);

    // Asynchronous reset in RUN cycle 2 aborts without a done.
    applyStimulus8(8'h33, 8'h11, 1'b0, 11'h044, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset outputs",
                   32'({bus8.busy, bus8.done, bus8.zero, bus8.ovf, bus8.bout, bus8.result}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) @(negedge clk);
    checkOutput("idle after abort", 32'({bus8.busy, bus8.done}), 32'(0));

    // Exhaustive N=4 with K=1 (sel 0) and K=4 (sel 1).
    for (int sel = 0; sel < 2; sel++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          for (int s = 0; s < 2; s++) begin
            applyStimulus4(sel, a, b, s);
            waitDone4(sel);
            @(negedge clk);
          end
  endtask

  initial begin
    bus8.start = 1'b0;  bus8.sub = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus4a.start = 1'b0; bus4a.sub = 1'b0; bus4a.a = '0; bus4a.b = '0;
    bus4b.start = 1'b0; bus4b.sub = 1'b0; bus4b.a = '0; bus4b.b = '0;
    fork
      monitor();
      runAll();
    join_any
    disable fork;
    checkOutput("dut8 queue drained",    32'(q8.size()),  32'(0));
    checkOutput("dut4 K1 queue drained", 32'(q4a.size()), 32'(0));
    checkOutput("dut4 K4 queue drained", 32'(q4b.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
